// File: rtl/float_mul_sp.sv
// float_mul_sp: IEEE-754 binary32 multiplier, round-to-nearest-even, flush-to-zero, one output register
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears out to +0
//   ain   : operand A (binary32)
//   bin   : operand B (binary32)
//   out   : product, registered one cycle after the operands are sampled
module float_mul_sp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ain,
    input  logic [31:0] bin,
    output logic [31:0] out
);
    logic [31:0]        out_q, out_d;
    logic               sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0]        prod;
    logic [22:0]        mant;
    logic               guard, sticky;
    logic [23:0]        rnd;
    logic signed [9:0]  e_sum, exp_r;
    logic [31:0]        normal;
    always_comb begin
        sign   = ain[31] ^ bin[31];
        a_zero = ~|ain[30:23];
        b_zero = ~|bin[30:23];
        a_nan  = (&ain[30:23]) & (|ain[22:0]);
        b_nan  = (&bin[30:23]) & (|bin[22:0]);
        a_inf  = (&ain[30:23]) & ~(|ain[22:0]);
        b_inf  = (&bin[30:23]) & ~(|bin[22:0]);
        prod   = {24'b0, 1'b1, ain[22:0]} * {24'b0, 1'b1, bin[22:0]};
        e_sum  = $signed({2'b0, ain[30:23]}) + $signed({2'b0, bin[30:23]}) - 10'sd127;
        // a product in [2,4) takes one extra normalisation step
        mant   = prod[47] ? prod[46:24] : prod[45:23];
        guard  = prod[47] ? prod[23] : prod[22];
        sticky = prod[47] ? |prod[22:0] : |prod[21:0];
        // rnd[23] is the rounding carry; rnd[22:0] is already zero when it is set
        rnd    = {1'b0, mant} + 24'(guard & (sticky | mant[0]));
        exp_r  = e_sum + $signed({9'b0, prod[47]}) + $signed({9'b0, rnd[23]});
        normal = (exp_r >= 10'sd255) ? {sign, 8'hFF, 23'h0} :
                 (exp_r <= 10'sd0)   ? {sign, 31'h0} :
                                       {sign, exp_r[7:0], rnd[22:0]};
        out_d  = (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) ? 32'h7FC0_0000 :
                 (a_inf | b_inf)   ? {sign, 8'hFF, 23'h0} :
                 (a_zero | b_zero) ? {sign, 31'h0} :
                                     normal;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= 32'h0;
        else        out_q <= out_d;
    end
    assign out = out_q;
endmodule

// File: tb/tb_float_mul_sp.sv
// tb_float_mul_sp: directed and random self-checking bench for float_mul_sp
module tb_float_mul_sp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] ain = 32'h3F80_0000;
    logic [31:0] bin = 32'h3F80_0000;
    logic [31:0] out;
    int          n_checks = 0;
    int          n_pass = 0;

    float_mul_sp dut (.clk(clk), .rst_n(rst_n), .ain(ain), .bin(bin), .out(out));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (a=%h b=%h)", tag, got, exp, ain, bin);
    endtask

    // Reference: exact integer product, then round the discarded remainder against one half.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s, an, bn, ai, bi, az, bz;
        logic [63:0] p, q, rem, half;
        int          e, sh;
        s  = a[31] ^ b[31];
        az = a[30:23] == 8'd0;
        bz = b[30:23] == 8'd0;
        an = a[30:23] == 8'd255 && a[22:0] != 0;
        bn = b[30:23] == 8'd255 && b[22:0] != 0;
        ai = a[30:23] == 8'd255 && a[22:0] == 0;
        bi = b[30:23] == 8'd255 && b[22:0] == 0;
        if (an || bn) return 32'h7FC0_0000;
        if ((ai && bz) || (bi && az)) return 32'h7FC0_0000;
        if (ai || bi) return {s, 8'hFF, 23'h0};
        if (az || bz) return {s, 31'h0};
        p  = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        sh = 23;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        int         k;
        k = $urandom_range(0, 31);
        e = (k == 0) ? 8'd0 : (k == 1) ? 8'd255 : 8'($urandom_range(1, 254));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    logic [31:0] da [12] = '{32'h4000_0000, 32'hBFC0_0000, 32'h3F80_0001, 32'h3FFF_FFFF,
                             32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0001, 32'h8000_0000,
                             32'h7F7F_FFFF, 32'h0080_0000, 32'h0000_0001, 32'h0000_0000};
    logic [31:0] db [12] = '{32'h4040_0000, 32'h4000_0000, 32'h3F80_0001, 32'h3FFF_FFFF,
                             32'h0000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000,
                             32'h4000_0000, 32'h3F00_0000, 32'h7F00_0000, 32'hFF80_0000};
    logic [31:0] de [12] = '{32'h40C0_0000, 32'hC040_0000, 32'h3F80_0002, 32'h407F_FFFE,
                             32'h7FC0_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h8000_0000,
                             32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000};

    initial begin
        logic [31:0] exp_v;
        #1 rst_n = 1'b0;
        #1 check("rst_async", out, 32'h0);
        repeat (2) @(posedge clk);
        #1 check("rst_hold", out, 32'h0);
        rst_n = 1'b1;
        #1 check("rst_release", out, 32'h0);
        @(posedge clk);
        #1 check("one_x_one", out, 32'h3F80_0000);
        for (int i = 0; i < 12; i++) begin
            ain = da[i];
            bin = db[i];
            @(posedge clk);
            #1 check($sformatf("dir%0d", i), out, de[i]);
        end
        ain = 32'h4000_0000;
        bin = 32'h4040_0000;
        @(posedge clk);
        #1 check("pre_mid_rst", out, 32'h40C0_0000);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_async", out, 32'h0);
        @(posedge clk);
        #1 check("rst_mid_hold", out, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            ain   = rand_op();
            bin   = rand_op();
            exp_v = ref_mul(ain, bin);
            @(posedge clk);
            #1 check("rand", out, exp_v);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
